// File: rtl/sensor_frame_rx_pkg.sv
// sensor_frame_rx_pkg: shared constants for the sensor status link.
// The transmit side uses the same header, checksum key and status bit indices.
// Contents:
//   HDR, SUM_KEY                       frame header byte and checksum key
//   KEY_LSB, CO_BIT, VIB_BIT, FAN_BIT  bit positions inside the status byte
//   PsHunt .. PsSum                    frame parser state encoding
//   frame_sum()                        checksum of a status/seq pair
package sensor_frame_rx_pkg;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] SUM_KEY = 8'h5A;

  localparam int unsigned KEY_LSB = 0;
  localparam int unsigned CO_BIT  = 4;
  localparam int unsigned VIB_BIT = 5;
  localparam int unsigned FAN_BIT = 6;

  localparam logic [1:0] PsHunt = 2'd0;
  localparam logic [1:0] PsStat = 2'd1;
  localparam logic [1:0] PsSeq  = 2'd2;
  localparam logic [1:0] PsSum  = 2'd3;

  function automatic logic [7:0] frame_sum(input logic [7:0] status, input logic [7:0] seq_byte);
    return status ^ seq_byte ^ SUM_KEY;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with input synchroniser.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); one bit lasts CLK_FREQ/BAUD cycles.
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   rx_i        asynchronous serial line, idle high
//   byte_vld_o  1-cycle pulse, byte_o holds a byte with a good stop bit
//   byte_o      last received byte (LSB received first)
//   frm_err_o   1-cycle pulse, stop bit sampled low and byte discarded
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       frm_err_o
);

  localparam int unsigned BitCyc  = CLK_FREQ / BAUD;
  localparam int unsigned HalfCyc = BitCyc / 2;
  localparam int unsigned CntW    = $clog2(BitCyc + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(BitCyc - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCyc - 1);

  localparam logic [1:0] RsIdle  = 2'd0;
  localparam logic [1:0] RsStart = 2'd1;
  localparam logic [1:0] RsData  = 2'd2;
  localparam logic [1:0] RsStop  = 2'd3;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            vld_q, vld_d;
  logic            ferr_q, ferr_d;

  // Synchroniser flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RsIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          st_d  = RsStart;
          cnt_d = '0;
        end
      end
      RsStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid start bit: a glitch, not a start bit.
          st_d  = rx_sync_q ? RsIdle : RsData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RsData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RsStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RsStop: begin
        if (cnt_q == BitLast) begin
          cnt_d  = '0;
          st_d   = RsIdle;
          vld_d  = rx_sync_q;
          ferr_d = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: st_d = RsIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= RsIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_vld_o = vld_q;
  assign byte_o     = shift_q;
  assign frm_err_o  = ferr_q;

endmodule

// File: rtl/sensor_frame_rx.sv
// sensor_frame_rx: decoder for the 4-byte sensor status frame carried over an 8N1 UART link.
// Frame: A5, status (bit7 = 0), seq, status ^ seq ^ 5A.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), TIMEOUT_BITS (inter-byte gap aborting a frame).
// Build option: define SEQ_CHECK_EN to drop duplicate frames and flag sequence gaps;
// without it every valid frame updates the outputs and seq_gap is tied low.
// Ports:
//   clk, rst (async, active high), data_rx (async serial line, idle high)
//   key_state, co_alarm, vib_alarm, fan_on, seq  status of the last accepted frame
//   frame_valid  1-cycle pulse when the status outputs update
//   sum_err      1-cycle pulse on checksum mismatch
//   frm_err      1-cycle pulse on a UART stop-bit error
//   seq_gap      1-cycle pulse with frame_valid when seq skipped (SEQ_CHECK_EN only)
module sensor_frame_rx
  import sensor_frame_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned TIMEOUT_BITS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_rx,
  output logic [3:0] key_state,
  output logic       co_alarm,
  output logic       vib_alarm,
  output logic       fan_on,
  output logic [7:0] seq,
  output logic       frame_valid,
  output logic       sum_err,
  output logic       frm_err,
  output logic       seq_gap
);

  localparam int unsigned BitCyc = CLK_FREQ / BAUD;
  localparam int unsigned ToCyc  = TIMEOUT_BITS * BitCyc;
  localparam int unsigned ToW    = $clog2(ToCyc + 1);
  localparam logic [ToW-1:0] ToLoad = ToW'(ToCyc - 1);

  logic       rx_vld, rx_ferr;
  logic [7:0] rx_byte;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_byte_rx (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_i      (data_rx),
    .byte_vld_o(rx_vld),
    .byte_o    (rx_byte),
    .frm_err_o (rx_ferr)
  );

  logic [1:0]     ps_q, ps_d;
  logic [6:0]     rx_stat_q, rx_stat_d;
  logic [7:0]     rx_seq_q, rx_seq_d;
  logic [ToW-1:0] to_q, to_d;
  logic [6:0]     stat_q, stat_d;
  logic [7:0]     seq_q, seq_d;
  logic           fv_q, fv_d;
  logic           se_q, se_d;
  logic           sum_hit;  // checksum byte completes a well-formed frame
  logic           take;     // that frame updates the outputs

  assign sum_hit = rx_vld && (ps_q == PsSum) &&
                   (rx_byte == frame_sum({1'b0, rx_stat_q}, rx_seq_q));

`ifdef SEQ_CHECK_EN
  logic have_prev_q;
  logic gap_q;

  // A repeated seq is a radio retransmit of the frame already shown.
  assign take = sum_hit && !(have_prev_q && (rx_seq_q == seq_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_prev_q <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      have_prev_q <= have_prev_q | take;
      gap_q       <= take && have_prev_q && (rx_seq_q != seq_q + 8'd1);
    end
  end

  assign seq_gap = gap_q;
`else
  assign take    = sum_hit;
  assign seq_gap = 1'b0;
`endif

  always_comb begin
    ps_d      = ps_q;
    rx_stat_d = rx_stat_q;
    rx_seq_d  = rx_seq_q;
    to_d      = to_q;
    stat_d    = stat_q;
    seq_d     = seq_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    if (rx_ferr) begin
      ps_d = PsHunt;
    end else if (rx_vld) begin
      to_d = ToLoad;
      case (ps_q)
        PsHunt: if (rx_byte == HDR) ps_d = PsStat;
        PsStat: begin
          if (!rx_byte[7]) begin
            rx_stat_d = rx_byte[6:0];
            ps_d      = PsSeq;
          end else if (rx_byte != HDR) begin
            ps_d = PsHunt;
          end
        end
        PsSeq: begin
          rx_seq_d = rx_byte;
          ps_d     = PsSum;
        end
        PsSum: begin
          ps_d = PsHunt;
          se_d = !sum_hit;
          if (take) begin
            stat_d = rx_stat_q;
            seq_d  = rx_seq_q;
            fv_d   = 1'b1;
          end
        end
        default: ps_d = PsHunt;
      endcase
    end else if (ps_q != PsHunt) begin
      if (to_q == '0) begin
        ps_d = PsHunt;
      end else begin
        to_d = to_q - ToW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q      <= PsHunt;
      rx_stat_q <= '0;
      rx_seq_q  <= '0;
      to_q      <= '0;
      stat_q    <= '0;
      seq_q     <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      ps_q      <= ps_d;
      rx_stat_q <= rx_stat_d;
      rx_seq_q  <= rx_seq_d;
      to_q      <= to_d;
      stat_q    <= stat_d;
      seq_q     <= seq_d;
      fv_q      <= fv_d;
      se_q      <= se_d;
    end
  end

  assign key_state   = stat_q[KEY_LSB +: 4];
  assign co_alarm    = stat_q[CO_BIT];
  assign vib_alarm   = stat_q[VIB_BIT];
  assign fan_on      = stat_q[FAN_BIT];
  assign seq         = seq_q;
  assign frame_valid = fv_q;
  assign sum_err     = se_q;
  assign frm_err     = rx_ferr;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// tb_sensor_frame_rx: randomized self-checking bench for sensor_frame_rx.
// A frame-level reference model (queue of pending bytes) predicts pulses and outputs per byte.
module tb_sensor_frame_rx;

  localparam int unsigned BitCyc = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_rx = 1'b1;
  logic [3:0] key_state;
  logic       co_alarm, vib_alarm, fan_on;
  logic [7:0] seq;
  logic       frame_valid, sum_err, frm_err, seq_gap;

  sensor_frame_rx #(
    .CLK_FREQ    (1_000_000),
    .BAUD        (100_000),
    .TIMEOUT_BITS(30)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_rx    (data_rx),
    .key_state  (key_state),
    .co_alarm   (co_alarm),
    .vib_alarm  (vib_alarm),
    .fan_on     (fan_on),
    .seq        (seq),
    .frame_valid(frame_valid),
    .sum_err    (sum_err),
    .frm_err    (frm_err),
    .seq_gap    (seq_gap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Pulse monitor: running totals only; the stimulus side takes snapshots.
  int          fv_cnt = 0, se_cnt = 0, fe_cnt = 0, gap_cnt = 0;
  int unsigned fv_cyc = 0;
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc = cyc;
    end
    if (sum_err) se_cnt++;
    if (frm_err) fe_cnt++;
    if (seq_gap) begin
      gap_cnt++;
      check_eq("gap_with_fv", 32'(frame_valid), 32'd1);
    end
    if (frame_valid || sum_err || frm_err)
      check_eq("pulse_excl", 32'(frame_valid) + 32'(sum_err) + 32'(frm_err), 32'd1);
  end

  // Reference model
  logic [7:0] mbuf[$];
  logic [6:0] m_stat = '0;
  logic [7:0] m_seq = '0;
`ifdef SEQ_CHECK_EN
  bit m_have = 1'b0;
`endif
  int e_fv, e_se, e_fe, e_gap;

  task automatic model_reset();
    mbuf.delete();
    m_stat = '0;
    m_seq  = '0;
`ifdef SEQ_CHECK_EN
    m_have = 1'b0;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop_bit);
    e_fv = 0; e_se = 0; e_fe = 0; e_gap = 0;
    if (!stop_bit) begin
      e_fe = 1;
      mbuf.delete();
    end else if (mbuf.size() == 0) begin
      if (b == 8'hA5) mbuf.push_back(b);
    end else if (mbuf.size() == 1) begin
      if (!b[7]) mbuf.push_back(b);
      else if (b != 8'hA5) mbuf.delete();
    end else if (mbuf.size() == 2) begin
      mbuf.push_back(b);
    end else begin
      if ((mbuf[1] ^ mbuf[2] ^ 8'h5A) == b) begin
`ifdef SEQ_CHECK_EN
        logic [7:0] nxt;
        nxt = m_seq + 8'd1;
        if (!(m_have && mbuf[2] == m_seq)) begin
          e_fv   = 1;
          e_gap  = (m_have && mbuf[2] != nxt) ? 1 : 0;
          m_stat = mbuf[1][6:0];
          m_seq  = mbuf[2];
          m_have = 1'b1;
        end
`else
        e_fv   = 1;
        m_stat = mbuf[1][6:0];
        m_seq  = mbuf[2];
`endif
      end else begin
        e_se = 1;
      end
      mbuf.delete();
    end
  endtask

  int          b_fv, b_se, b_fe, b_gap;
  int unsigned byte_start;

  task automatic snap();
    b_fv = fv_cnt; b_se = se_cnt; b_fe = fe_cnt; b_gap = gap_cnt;
  endtask

  task automatic check_pulses(input int xfv, input int xse, input int xfe, input int xgap);
    check_eq("frame_valid_cnt", 32'(fv_cnt - b_fv), 32'(xfv));
    check_eq("sum_err_cnt", 32'(se_cnt - b_se), 32'(xse));
    check_eq("frm_err_cnt", 32'(fe_cnt - b_fe), 32'(xfe));
    check_eq("seq_gap_cnt", 32'(gap_cnt - b_gap), 32'(xgap));
  endtask

  task automatic check_outputs();
    check_eq("status", {25'd0, fan_on, vib_alarm, co_alarm, key_state}, {25'd0, m_stat});
    check_eq("seq", {24'd0, seq}, {24'd0, m_seq});
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    data_rx    = 1'b0;
    byte_start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (BitCyc) @(posedge clk);
      #1 data_rx = b[i];
    end
    repeat (BitCyc) @(posedge clk);
    #1 data_rx = stop_bit;
    repeat (BitCyc) @(posedge clk);
    #1 data_rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    snap();
    model_byte(b, stop_bit);
    drive_byte(b, stop_bit);
    repeat (4) @(posedge clk);
    #1;
    check_pulses(e_fv, e_se, e_fe, e_gap);
    check_outputs();
    if (e_fv != 0) check_eq("fv_latency", fv_cyc - byte_start, 32'd99);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    if (n >= 350) mbuf.delete();
  endtask

  task automatic send_frame(input logic [7:0] st, input logic [7:0] sq, input logic [7:0] flip);
    send(8'hA5, 1'b1);
    send(st, 1'b1);
    send(sq, 1'b1);
    send((st ^ sq ^ 8'h5A) ^ flip, 1'b1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fb[4];
    logic [7:0] st, sq;
    int         kind, pos;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_status", {28'd0, fan_on, vib_alarm, co_alarm, key_state[0]}, 32'd0);
    check_eq("rst_key", {28'd0, key_state}, 32'd0);
    check_eq("rst_seq", {24'd0, seq}, 32'd0);
    check_eq("rst_pulses", {28'd0, frame_valid, sum_err, frm_err, seq_gap}, 32'd0);

    // Basic frame with literal expectations
    send_frame(8'h15, 8'h03, 8'h00);
    check_eq("a_key", {28'd0, key_state}, 32'h5);
    check_eq("a_alarms", {29'd0, fan_on, vib_alarm, co_alarm}, 32'b001);
    check_eq("a_seq", {24'd0, seq}, 32'h03);

    // Bad checksum
    snap();
    send_frame(8'h15, 8'h03, 8'h01);
    check_pulses(0, 1, 0, 0);

    // Resync on repeated header
    send(8'hA5, 1'b1);
    send_frame(8'h60, 8'h07, 8'h00);
    check_eq("r_alarms", {29'd0, fan_on, vib_alarm, co_alarm}, 32'b110);
    check_eq("r_seq", {24'd0, seq}, 32'h07);

    // Stop-bit error mid-frame, then a clean frame
    send(8'hA5, 1'b1);
    send(8'h15, 1'b1);
    send(8'h03, 1'b0);
    idle(15);
    send_frame(8'h15, 8'h03, 8'h00);

    // Timeout abort
    snap();
    send(8'hA5, 1'b1);
    send(8'h15, 1'b1);
    idle(350);
    send(8'h03, 1'b1);
    send(8'h4C, 1'b1);
    check_pulses(0, 0, 0, 0);

    // Short glitch on the idle line
    snap();
    @(posedge clk); #1 data_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 data_rx = 1'b1;
    idle(150);
    check_pulses(0, 0, 0, 0);

    // Duplicate then skipped sequence (dropped/flagged only with SEQ_CHECK_EN)
    send_frame(8'h15, 8'h03, 8'h00);
    send_frame(8'h15, 8'h05, 8'h00);

    // Reset in the middle of the last byte of a frame
    send(8'hA5, 1'b1);
    send(8'h22, 1'b1);
    send(8'h09, 1'b1);
    @(posedge clk); #1 data_rx = 1'b0;
    repeat (35) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    data_rx = 1'b1;
    rst     = 1'b0;
    model_reset();
    snap();
    idle(200);
    check_pulses(0, 0, 0, 0);
    check_outputs();

    // Randomized traffic
    for (int s = 0; s < 50; s++) begin
      kind = $urandom_range(0, 7);
      st   = 8'($urandom) & 8'h7F;
      case ($urandom_range(0, 3))
        0:       sq = m_seq;
        1:       sq = 8'($urandom);
        default: sq = m_seq + 8'd1;
      endcase
      fb[0] = 8'hA5;
      fb[1] = st;
      fb[2] = sq;
      fb[3] = st ^ sq ^ 8'h5A;
      case (kind)
        3: fb[3] = fb[3] ^ (8'h01 << $urandom_range(0, 7));
        4: fb[1] = st | 8'h80;
        default: ;
      endcase
      if (kind == 5) begin
        pos = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) send(fb[i], (i == pos) ? 1'b0 : 1'b1);
      end else if (kind == 6) begin
        pos = $urandom_range(1, 3);
        for (int i = 0; i < 4; i++) begin
          if (i == pos) idle(400);
          send(fb[i], 1'b1);
        end
      end else if (kind == 7) begin
        send(8'($urandom), 1'b1);
        snap();
        @(posedge clk); #1 data_rx = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 data_rx = 1'b1;
        idle(20);
        check_pulses(0, 0, 0, 0);
      end else begin
        for (int i = 0; i < 4; i++) send(fb[i], 1'b1);
      end
      idle($urandom_range(0, 20));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
